// File: rtl/seq_digit_multiplier.sv
// Sequential unsigned multiplier: one DIGIT-bit slice of B per clock into a 2*WIDTH accumulator.
// Define SEQ_MULT_SIGNED_EN to treat operands as two's complement (adds one FIX cycle).
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one slice of B multiplied and accumulated per cycle
// FIX   | sign correction of the magnitude product (SEQ_MULT_SIGNED_EN only)
// DONE  | out_valid high, P_out held until out_ready
module seq_digit_multiplier #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P_out,
    output logic                 busy
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef SEQ_MULT_SIGNED_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [DIGIT-1:0]     w_slice;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_pp_sh;
    logic                 w_last;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 r_neg;
`endif

    assign w_last  = (r_cnt == CNT_W'(NSLICE - 1));
    assign w_slice = DIGIT'(r_b >> (r_cnt * DIGIT));
    // Partial product is at most WIDTH+DIGIT bits; widening to 2*WIDTH keeps the add overflow-free
    assign w_pp    = (2*WIDTH)'(r_a) * (2*WIDTH)'(w_slice);
    assign w_pp_sh = w_pp << (r_cnt * DIGIT);
    assign P_out   = r_acc;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
                if (w_last) w_next = S_FIX;
`else
                if (w_last) w_next = S_DONE;
`endif
            end
`ifdef SEQ_MULT_SIGNED_EN
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            r_neg <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef SEQ_MULT_SIGNED_EN
                        // Magnitudes kept unsigned so -2^(W-1) stays exact
                        r_a   <= A_in[WIDTH-1] ? (~A_in + WIDTH'(1)) : A_in;
                        r_b   <= B_in[WIDTH-1] ? (~B_in + WIDTH'(1)) : B_in;
                        r_neg <= A_in[WIDTH-1] ^ B_in[WIDTH-1];
`else
                        r_a   <= A_in;
                        r_b   <= B_in;
`endif
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + w_pp_sh;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
`ifdef SEQ_MULT_SIGNED_EN
                S_FIX: begin
                    if (r_neg) r_acc <= -r_acc;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_digit_multiplier.sv
// Bench for seq_digit_multiplier: transaction-level model checked every cycle plus literal expectations.
// Honours SEQ_MULT_SIGNED_EN when the design is built with it.
module tb_seq_digit_multiplier;

    localparam int W = 32;
`ifdef SEQ_MULT_SIGNED_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A_in;
    logic [W-1:0]  B_in;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] P_out;
    logic          busy;

    int errors = 0;
    int checks = 0;

    seq_digit_multiplier #(.WIDTH(W), .DIGIT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A_in     (A_in),
        .B_in     (B_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .P_out    (P_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    // Model: 0 = waiting for operands, 1 = computing, 2 = result offered
    int          m_st   = 0;
    int          m_cnt  = 0;
    bit          m_init = 0;
    logic [63:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_st   = 0;
        end else if (m_init) begin
            case (m_st)
                0: if (in_valid) begin
                    m_prod = prod(A_in, B_in);
                    m_cnt  = LAT;
                    m_st   = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_st = 2;
                end
                default: if (out_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model in_ready", 64'(in_ready), 64'(m_st == 0));
            chk("model out_valid", 64'(out_valid), 64'(m_st == 2));
            chk("model busy", 64'(busy), 64'(m_st == 1));
            if (m_st == 2) chk("model P_out", P_out, m_prod);
        end
    end

    // Called at a negedge with the DUT idle; presents operands for exactly one edge
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        A_in     = a;
        B_in     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input logic [63:0] exp, input int exp_n, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        chk({name, " latency"}, 64'(n), 64'(exp_n));
        chk({name, " product"}, P_out, exp);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b1;
        A_in      = 32'h0000_0003;
        B_in      = 32'h0000_0005;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset P_out", P_out, 64'd0);

        // in_valid held through reset: capture happens on the first edge after release
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(64'h0000_0000_0000_000F, LAT, "basic");
        @(negedge clk);

        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef SEQ_MULT_SIGNED_EN
        wait_valid(64'h0000_0000_0000_0001, LAT, "max");
`else
        wait_valid(64'hFFFF_FFFE_0000_0001, LAT, "max");
`endif
        @(negedge clk);

        out_ready = 1'b0;
        accept(32'h1234_5678, 32'h9ABC_DEF0);
`ifdef SEQ_MULT_SIGNED_EN
        wait_valid(64'hF8CC_93D6_242D_2080, LAT, "bp");
`else
        wait_valid(64'h0B00_EA4E_242D_2080, LAT, "bp");
`endif
        in_valid = 1'b1;
        A_in     = 32'h0000_0001;
        B_in     = 32'h0000_0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef SEQ_MULT_SIGNED_EN
            chk("bp hold P_out", P_out, 64'hF8CC_93D6_242D_2080);
`else
            chk("bp hold P_out", P_out, 64'h0B00_EA4E_242D_2080);
`endif
            chk("bp hold in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort P_out", P_out, 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort no result", 64'(seen), 64'd0);

        in_valid = 1'b1;
        A_in     = 32'd7;
        B_in     = 32'd6;
        wait_valid(64'd42, LAT + 1, "b2b first");
        A_in = 32'h0000_0000;
        B_in = 32'hFFFF_FFFF;
        wait_valid(64'd0, LAT + 2, "b2b second");
        in_valid = 1'b0;
        @(negedge clk);

        accept(32'hFFFF_FFFF, 32'h0000_0002);
`ifdef SEQ_MULT_SIGNED_EN
        wait_valid(64'hFFFF_FFFF_FFFF_FFFE, LAT, "neg one");
`else
        wait_valid(64'h0000_0001_FFFF_FFFE, LAT, "neg one");
`endif
        @(negedge clk);

        accept(32'h8000_0000, 32'h8000_0000);
        wait_valid(64'h4000_0000_0000_0000, LAT, "min squared");
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
